pll_reset_sequencer: RTL and testbench

PLL lock supervisor and system reset sequencer; drives the PLL core's active-low reset (`RESETB`) and consumes its `LOCK` output. Runs on the 12 MHz reference clock, never on the PLL output, so it keeps running while the PLL is held in reset or has lost lock. Produces a debounced, stretched `sys_reset` for logic in the PLL output domain and re-pulses the PLL if lock is not reached within a timeout. Instantiated at top level beside `pll`.

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/pll_reset_sequencer_if.sv | 30 +++
 rtl/sync2.sv | 31 +++
 rtl/pll_reset_sequencer.sv | 132 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL lock supervisor / reset sequencer.
// Contents:
//   state_t         - sequencer state encoding (3 bits)
//   DEF_*           - default timing constants, in reference-clock cycles
//   cnt_width()     - width of the shared state counter for a parameter set
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int DEF_LOCK_STABLE    = 1024;
  localparam int DEF_RESET_HOLD     = 16;
  localparam int DEF_LOCK_TIMEOUT   = 120000;  // 10 ms at 12 MHz
  localparam int DEF_PLL_RST_CYCLES = 12;

  // One counter serves every state, so it must hold the largest of the limits.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL-facing and status signals of the sequencer.
//   locked       - PLL LOCK (asynchronous to the reference clock)
//   clear_stats  - synchronous clear of the statistics outputs
//   pll_resetb   - PLL RESETB, low holds the PLL in reset
//   sys_reset    - active-high reset for the PLL output domain
//   ready        - high only while the sequencer is in RUN
//   lock_lost    - sticky flag, set on lock loss in RUN
//   retry_count  - saturating count of timeout re-pulses
//   loss_count   - saturating count of lock losses in RUN
// master = sequencer side, slave = consumer / environment side.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       clear_stats;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  locked, clear_stats,
    output pll_resetb, sys_reset, ready, lock_lost, retry_count, loss_count
  );

  modport slave (
    output locked, clear_stats,
    input  pll_resetb, sys_reset, ready, lock_lost, retry_count, loss_count
  );
endinterface

// File: rtl/sync2.sv
// sync2: single-bit two-flop synchronizer with synchronous reset to 0.
//   clk   - destination clock
//   reset - synchronous, active-high; clears both stages
//   d     - asynchronous input
//   q     - synchronized output, 2 cycles of latency
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL lock supervisor and system reset sequencer.
// Runs on the PLL reference clock so it keeps working while the PLL is in
// reset or unlocked. Pulses RESETB, qualifies LOCK, stretches sys_reset,
// and re-pulses the PLL when lock does not arrive within LOCK_TIMEOUT.
// Ports:
//   clk   - 12 MHz reference clock (same net as PLL REFERENCECLK)
//   reset - synchronous, active-high; always restarts with a PLL pulse
//   bus   - pll_reset_sequencer_if.master (lock input, resets, status)
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int RESET_HOLD     = DEF_RESET_HOLD,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  pll_reset_sequencer_if.master bus
);
  localparam int CW = cnt_width(LOCK_STABLE, RESET_HOLD, LOCK_TIMEOUT, PLL_RST_CYCLES);

  // Each limit is compared against the count before the edge that leaves the
  // state, so the state lasts exactly <limit> cycles.
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD - 1);

  logic          locked_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          retry_inc, loss_inc;
  logic          pll_resetb_q, pll_resetb_d;
  logic          sys_reset_q, sys_reset_d;
  logic          ready_q, ready_d;
  logic          lock_lost_q, lock_lost_d;
  logic [3:0]    retry_count_q, retry_count_d;
  logic [7:0]    loss_count_q, loss_count_d;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;  // no limit in RUN; hold instead of free-running
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they flop in step with it.
    pll_resetb_d = (state_d != PLL_RST);
    sys_reset_d  = (state_d != RUN);
    ready_d      = (state_d == RUN);

    // Statistics: clear wins over a same-cycle increment; counters saturate.
    retry_count_d = retry_count_q;
    loss_count_d  = loss_count_q;
    lock_lost_d   = lock_lost_q;
    if (bus.clear_stats) begin
      retry_count_d = '0;
      loss_count_d  = '0;
      lock_lost_d   = 1'b0;
    end else begin
      if (retry_inc && (retry_count_q != '1)) retry_count_d = retry_count_q + 4'd1;
      if (loss_inc && (loss_count_q != '1)) loss_count_d = loss_count_q + 8'd1;
      if (loss_inc) lock_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      retry_count_q <= '0;
      loss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_reset_q   <= sys_reset_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
      retry_count_q <= retry_count_d;
      loss_count_q  <= loss_count_d;
    end
  end

  assign bus.pll_resetb  = pll_resetb_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.ready       = ready_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.retry_count = retry_count_q;
  assign bus.loss_count  = loss_count_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed bench for pll_reset_sequencer with small
// timing parameters. Stimulus schedules expected output values against an
// edge index; a negedge monitor compares each one when its edge arrives.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int S_RESETB = 0;
  localparam int S_SYSRST = 1;
  localparam int S_READY  = 2;
  localparam int S_LOST   = 3;
  localparam int S_RETRY  = 4;
  localparam int S_LOSS   = 5;

  typedef struct {
    int          at;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .LOCK_STABLE    (8),
    .RESET_HOLD     (4),
    .LOCK_TIMEOUT   (50),
    .PLL_RST_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_RESETB: return {31'd0, bus.pll_resetb};
      S_SYSRST: return {31'd0, bus.sys_reset};
      S_READY:  return {31'd0, bus.ready};
      S_LOST:   return {31'd0, bus.lock_lost};
      S_RETRY:  return {28'd0, bus.retry_count};
      S_LOSS:   return {24'd0, bus.loss_count};
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Compare every scheduled value whose edge has been reached.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        n_cmp++;
        assert (obs(sb[i].sel) === sb[i].val && sb[i].at == cyc)
          $display("chk %s edge=%0d value=%0d", sb[i].tag, cyc, obs(sb[i].sel));
        else begin
          n_bad++;
          $error("FAIL %s: observed %0d expected %0d (edge %0d, due %0d)",
                 sb[i].tag, obs(sb[i].sel), sb[i].val, cyc, sb[i].at);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic expect_at(input int at, input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.at  = at;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One-cycle reset; returns the edge index at which reset was sampled.
  task automatic do_reset(output int r);
    reset = 1'b1;
    step(1);
    r = cyc;
    reset = 1'b0;
  endtask

  initial begin
    int r, t, t2, d, c;
    bus.locked      = 1'b0;
    bus.clear_stats = 1'b0;

    // 1. Reset values, then timeout re-pulses with retry_count saturating.
    reset = 1'b1;
    step(3);
    r = cyc;
    reset = 1'b0;
    expect_at(r, S_RESETB, 0, "reset_pll_resetb");
    expect_at(r, S_SYSRST, 1, "reset_sys_reset");
    expect_at(r, S_READY,  0, "reset_ready");
    expect_at(r, S_LOST,   0, "reset_lock_lost");
    expect_at(r, S_RETRY,  0, "reset_retry");
    expect_at(r, S_LOSS,   0, "reset_loss");
    expect_at(r + 2,  S_RESETB, 0, "pll_rst_3rd_cycle");
    expect_at(r + 3,  S_RESETB, 1, "pll_rst_release");
    expect_at(r + 52, S_RESETB, 1, "pre_timeout");
    expect_at(r + 52, S_RETRY,  0, "pre_timeout_retry");
    for (int k = 1; k <= 16; k++) begin
      expect_at(r + 53 * k, S_RESETB, 0, $sformatf("timeout_%0d", k));
      expect_at(r + 53 * k, S_RETRY, (k < 15) ? k : 15, $sformatf("retry_%0d", k));
      if (k <= 2) begin
        expect_at(r + 53 * k + 2, S_RESETB, 0, $sformatf("repulse_low_%0d", k));
        expect_at(r + 53 * k + 3, S_RESETB, 1, $sformatf("repulse_end_%0d", k));
      end
    end
    step_to(r + 53 * 16 + 4);

    // 2. Lock 10 cycles into WAIT_LOCK; release 14 edges after first sample.
    do_reset(r);
    expect_at(r, S_RETRY, 0, "s2_retry_cleared");
    step_to(r + 12);
    bus.locked = 1'b1;
    t = r + 13;
    expect_at(t + 13, S_SYSRST, 1, "s2_sys_reset_before");
    expect_at(t + 13, S_READY,  0, "s2_ready_before");
    expect_at(t + 14, S_SYSRST, 0, "s2_sys_reset_release");
    expect_at(t + 14, S_READY,  1, "s2_ready_release");
    expect_at(t + 14, S_RETRY,  0, "s2_retry_zero");
    step_to(t + 16);

    // Sub-cycle glitch between edges is never sampled.
    #2 bus.locked = 1'b0;
    #3 bus.locked = 1'b1;
    expect_at(cyc + 3, S_READY, 1, "glitch_ready");
    expect_at(cyc + 3, S_LOST,  0, "glitch_lock_lost");
    step(4);

    // 3. One-cycle drop at cycle 5 of STABILIZE restarts qualification.
    bus.locked = 1'b0;
    do_reset(r);
    step_to(r + 4);
    bus.locked = 1'b1;
    t = r + 5;
    d = t + 2 + 5;
    step_to(d - 1);
    bus.locked = 1'b0;
    expect_at(t + 14, S_SYSRST, 1, "s3_no_early_release");
    expect_at(d + 14, S_READY,  0, "s3_ready_before");
    expect_at(d + 15, S_READY,  1, "s3_ready_release");
    expect_at(d + 15, S_SYSRST, 0, "s3_sys_reset_release");
    expect_at(d + 15, S_LOSS,   0, "s3_loss_zero");
    expect_at(d + 15, S_LOST,   0, "s3_lock_lost_zero");
    step(1);
    bus.locked = 1'b1;
    step_to(d + 17);

    // 4. Lock loss in RUN, then relock.
    c = cyc;
    bus.locked = 1'b0;
    t = c + 1;
    expect_at(t + 1, S_READY,  1, "s4_ready_still");
    expect_at(t + 2, S_SYSRST, 1, "s4_sys_reset");
    expect_at(t + 2, S_READY,  0, "s4_ready_drop");
    expect_at(t + 2, S_LOST,   1, "s4_lock_lost");
    expect_at(t + 2, S_LOSS,   1, "s4_loss_count");
    step_to(t + 5);
    bus.locked = 1'b1;
    t2 = t + 6;
    expect_at(t2 + 13, S_READY,  0, "s4_relock_before");
    expect_at(t2 + 14, S_READY,  1, "s4_relock_release");
    expect_at(t2 + 14, S_SYSRST, 0, "s4_relock_sys_reset");
    expect_at(t2 + 14, S_LOST,   1, "s4_lock_lost_sticky");
    step_to(t2 + 16);

    // 5a. clear_stats in the same cycle as a lock-loss increment.
    c = cyc;
    bus.locked = 1'b0;
    t = c + 1;
    step_to(t + 1);
    bus.clear_stats = 1'b1;
    expect_at(t + 2, S_LOSS,  0, "s5_clear_loss");
    expect_at(t + 2, S_LOST,  0, "s5_clear_lost");
    expect_at(t + 2, S_READY, 0, "s5_ready_drop");
    step(1);
    bus.clear_stats = 1'b0;
    bus.locked = 1'b1;
    t2 = t + 3;
    expect_at(t2 + 14, S_READY, 1, "s5_relock");
    step_to(t2 + 15);

    // 5b. 300 lock losses saturate loss_count at 255.
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      bus.locked = 1'b0;
      t = c + 1;
      if (i == 0 || i == 1 || i == 254 || i == 255 || i == 299)
        expect_at(t + 2, S_LOSS, (i < 255) ? i + 1 : 255, $sformatf("s5_loss_%0d", i + 1));
      step(1);
      bus.locked = 1'b1;
      step(15);
    end
    expect_at(cyc + 1, S_LOSS,  255, "s5_loss_saturated");
    expect_at(cyc + 1, S_READY, 1,   "s5_run_after_losses");
    step(2);

    // 6. One-cycle reset in RUN with lock high; PLL re-pulsed, then relock.
    reset = 1'b1;
    step(1);
    r = cyc;
    reset = 1'b0;
    bus.locked = 1'b0;
    expect_at(r, S_RESETB, 0, "s6_pll_resetb");
    expect_at(r, S_SYSRST, 1, "s6_sys_reset");
    expect_at(r, S_READY,  0, "s6_ready");
    expect_at(r, S_LOSS,   0, "s6_loss_cleared");
    expect_at(r + 3, S_RESETB, 1, "s6_pll_release");
    step_to(r + 6);
    bus.locked = 1'b1;
    t = r + 7;
    expect_at(t + 13, S_SYSRST, 1, "s6_before");
    expect_at(t + 14, S_SYSRST, 0, "s6_sys_reset_release");
    expect_at(t + 14, S_READY,  1, "s6_ready_release");
    expect_at(t + 14, S_RETRY,  0, "s6_retry_zero");
    step_to(t + 16);

    for (int k = 0; k < 200 && sb.size() > 0; k++) step(1);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
